// File: rtl/control_sequencer.sv
// Hardwired multicycle control unit for the single-bus datapath: fetches via
// PC/MAR/MDR/IR and sequences three-operand register ALU instructions.
module control_sequencer #(
  parameter logic [4:0] NOP_OP     = 5'h1A,
  parameter logic [4:0] HALT_OP    = 5'h1B,
  parameter logic [4:0] ALU_MAX_OP = 5'h0C
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic        stop,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        reg_out,
  output logic [3:0]  reg_out_sel,
  output logic        reg_in,
  output logic [3:0]  reg_in_sel,
  output logic [4:0]  alu_op,
  output logic        running,
  output logic        halted,
  output logic        illegal_op
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_e;

  state_e state_q, state_d;
  logic   first_t1_q, first_t1_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_halt, is_nop, is_illegal;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign is_alu     = (opcode <= ALU_MAX_OP);
  assign is_halt    = (opcode == HALT_OP);
  assign is_nop     = (opcode == NOP_OP);
  assign is_illegal = !(is_alu || is_halt || is_nop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers; blocking here would create ordering races.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= S_IDLE;
      first_t1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_t1_q <= first_t1_d;
    end
  end

  // Next-state logic; stop is only honoured at an instruction boundary.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d    = state_q;
    first_t1_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        state_d    = S_T1;
        first_t1_d = 1'b1;
      end
      S_T1: if (mem_ready) state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        if (is_alu)       state_d = S_T4;
        else if (is_halt) state_d = S_HALT;
        else              state_d = stop ? S_IDLE : S_T0;
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = stop ? S_IDLE : S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode: only one bus driver is ever enabled per state.
  always_comb begin
    PCout       = 1'b0;
    Zlowout     = 1'b0;
    MDRout      = 1'b0;
    MARin       = 1'b0;
    Zin         = 1'b0;
    PCin        = 1'b0;
    MDRin       = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    IncPC       = 1'b0;
    Read        = 1'b0;
    reg_out     = 1'b0;
    reg_out_sel = 4'd0;
    reg_in      = 1'b0;
    reg_in_sel  = 4'd0;
    alu_op      = 5'd0;
    illegal_op  = 1'b0;
    running     = (state_q != S_IDLE) && (state_q != S_HALT);
    halted      = (state_q == S_HALT);
    unique case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        // PC write-back only once, however long memory stalls.
        Zlowout = first_t1_q;
        PCin    = first_t1_q;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (is_alu) begin
          reg_out     = 1'b1;
          reg_out_sel = rb;
          Yin         = 1'b1;
        end
        illegal_op = is_illegal;
      end
      S_T4: begin
        reg_out     = 1'b1;
        reg_out_sel = rc;
        Zin         = 1'b1;
        alu_op      = opcode;
      end
      S_T5: begin
        Zlowout    = 1'b1;
        reg_in     = 1'b1;
        reg_in_sel = ra;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: expected strobe vectors are queued
// per cycle from hand-written state templates and compared against the DUT.
module tb_control_sequencer;

  localparam logic [4:0] NOP_OP  = 5'h1A;
  localparam logic [4:0] HALT_OP = 5'h1B;

  typedef struct packed {
    logic       pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in;
    logic       mdr_in, ir_in, y_in, inc_pc, read, reg_out;
    logic [3:0] reg_out_sel;
    logic       reg_in;
    logic [3:0] reg_in_sel;
    logic [4:0] alu_op;
    logic       running, halted, illegal_op;
  } out_t;

  logic        clock = 1'b0;
  logic        clear_n, start, stop, mem_ready;
  logic [31:0] ir;
  out_t        dut_o;

  out_t  sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start       (start),
    .stop        (stop),
    .mem_ready   (mem_ready),
    .ir          (ir),
    .PCout       (dut_o.pc_out),
    .Zlowout     (dut_o.zlow_out),
    .MDRout      (dut_o.mdr_out),
    .MARin       (dut_o.mar_in),
    .Zin         (dut_o.z_in),
    .PCin        (dut_o.pc_in),
    .MDRin       (dut_o.mdr_in),
    .IRin        (dut_o.ir_in),
    .Yin         (dut_o.y_in),
    .IncPC       (dut_o.inc_pc),
    .Read        (dut_o.read),
    .reg_out     (dut_o.reg_out),
    .reg_out_sel (dut_o.reg_out_sel),
    .reg_in      (dut_o.reg_in),
    .reg_in_sel  (dut_o.reg_in_sel),
    .alu_op      (dut_o.alu_op),
    .running     (dut_o.running),
    .halted      (dut_o.halted),
    .illegal_op  (dut_o.illegal_op)
  );

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h2A5C};
  endfunction

  // Expected output templates, one per state.
  function automatic out_t e_idle();
    out_t e = '0;
    return e;
  endfunction

  function automatic out_t e_halt();
    out_t e = '0;
    e.halted = 1'b1;
    return e;
  endfunction

  function automatic out_t e_t0();
    out_t e = '0;
    e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.z_in = 1'b1;
    e.running = 1'b1;
    return e;
  endfunction

  function automatic out_t e_t1(input logic first);
    out_t e = '0;
    e.read = 1'b1; e.mdr_in = 1'b1; e.running = 1'b1;
    e.zlow_out = first; e.pc_in = first;
    return e;
  endfunction

  function automatic out_t e_t2();
    out_t e = '0;
    e.mdr_out = 1'b1; e.ir_in = 1'b1; e.running = 1'b1;
    return e;
  endfunction

  function automatic out_t e_t3_alu(input logic [3:0] rb);
    out_t e = '0;
    e.reg_out = 1'b1; e.reg_out_sel = rb; e.y_in = 1'b1; e.running = 1'b1;
    return e;
  endfunction

  function automatic out_t e_t3_other(input logic illegal);
    out_t e = '0;
    e.running = 1'b1; e.illegal_op = illegal;
    return e;
  endfunction

  function automatic out_t e_t4(input logic [3:0] rc, input logic [4:0] op);
    out_t e = '0;
    e.reg_out = 1'b1; e.reg_out_sel = rc; e.z_in = 1'b1; e.alu_op = op;
    e.running = 1'b1;
    return e;
  endfunction

  function automatic out_t e_t5(input logic [3:0] ra);
    out_t e = '0;
    e.zlow_out = 1'b1; e.reg_in = 1'b1; e.reg_in_sel = ra; e.running = 1'b1;
    return e;
  endfunction

  task automatic check(input string tag, input out_t got, input out_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven: queue the expectation
  // for the current state, sample once outputs settle, then move on a cycle.
  task automatic cyc(input string tag, input out_t exp);
    out_t e;
    sb_q.push_back(exp);
    #1;
    e = sb_q.pop_front();
    check(tag, dut_o, e);
    @(negedge clock);
  endtask

  task automatic fetch(input int waits);
    cyc("t0", e_t0());
    for (int i = 0; i <= waits; i++) begin
      mem_ready = (i == waits);
      cyc("t1", e_t1(i == 0));
    end
    mem_ready = 1'b1;
    cyc("t2", e_t2());
  endtask

  initial begin
    clear_n = 1'b0; start = 1'b0; stop = 1'b0; mem_ready = 1'b0;
    ir = '0;
    @(negedge clock);

    for (int i = 0; i < 3; i++) begin
      start = i[0];
      cyc("reset_hold", e_idle());
    end

    // AND R2 <- R5 & R6, zero-wait memory; back to T0 on cycle 7.
    clear_n = 1'b1; start = 1'b1; mem_ready = 1'b1;
    ir = mk_ir(5'h04, 4'd2, 4'd5, 4'd6);
    cyc("idle_start", e_idle());
    fetch(0);
    cyc("and_t3", e_t3_alu(4'd5));
    cyc("and_t4", e_t4(4'd6, 5'h04));
    cyc("and_t5", e_t5(4'd2));

    // Illegal opcode with three memory wait cycles.
    ir = mk_ir(5'h1F, 4'd1, 4'd3, 4'd7);
    fetch(3);
    cyc("ill_t3", e_t3_other(1'b1));

    ir = mk_ir(NOP_OP, 4'd9, 4'd10, 4'd11);
    fetch(0);
    cyc("nop_t3", e_t3_other(1'b0));

    // R5 <- R5 | R5 with stop raised at T3; instruction still completes.
    ir = mk_ir(5'h01, 4'd5, 4'd5, 4'd5);
    fetch(0);
    stop = 1'b1;
    cyc("stop_t3", e_t3_alu(4'd5));
    cyc("stop_t4", e_t4(4'd5, 5'h01));
    cyc("stop_t5", e_t5(4'd5));
    stop = 1'b0;
    cyc("stop_idle", e_idle());

    // Asynchronous clear during a memory wait, then a clean restart.
    ir = mk_ir(5'h04, 4'd2, 4'd5, 4'd6);
    cyc("clr_t0", e_t0());
    mem_ready = 1'b0;
    cyc("clr_t1", e_t1(1'b1));
    clear_n = 1'b0;
    cyc("clr_async", e_idle());
    clear_n = 1'b1;
    cyc("clr_idle", e_idle());
    fetch(0);
    cyc("re_t3", e_t3_alu(4'd5));
    cyc("re_t4", e_t4(4'd6, 5'h04));
    cyc("re_t5", e_t5(4'd2));

    // HALT is absorbing regardless of start/stop.
    ir = mk_ir(HALT_OP, 4'd0, 4'd0, 4'd0);
    fetch(0);
    cyc("halt_t3", e_t3_other(1'b0));
    for (int i = 0; i < 4; i++) begin
      start = i[0]; stop = i[1];
      cyc("halted", e_halt());
    end
    clear_n = 1'b0;
    cyc("halt_clear", e_idle());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
